// File: rtl/lm32_dtlb_refill_pkg.sv
// rtl/lm32_dtlb_refill_pkg.sv - shared DTLB refill walker types and constants
package lm32_dtlb_refill_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_L1    = 3'd1,
        S_L2    = 3'd2,
        S_WR_V  = 3'd3,
        S_WR_P  = 3'd4,
        S_DONE  = 3'd5,
        S_FAULT = 3'd6
    } walk_state_t;

    localparam logic [4:0] LM32_CSR_TLB_VADDRESS = 5'h11;
    localparam logic [4:0] LM32_CSR_TLB_PADDRESS = 5'h12;

    localparam int PTE_VALID_BIT = 0;
    localparam int L1_IDX_HI     = 31;
    localparam int L1_IDX_LO     = 22;
    localparam int L2_IDX_HI     = 21;
    localparam int L2_IDX_LO     = 12;

    function automatic logic pte_valid(input logic [31:0] pte);
        return pte[PTE_VALID_BIT];
    endfunction

endpackage

// File: rtl/lm32_dtlb_refill.sv
// rtl/lm32_dtlb_refill.sv - two-level page-table walker that refills the DTLB via CSR writes
module lm32_dtlb_refill
    import lm32_dtlb_refill_pkg::*;
#(
    parameter int page_size = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable,
    input  logic        start,
    input  logic [31:0] miss_addr,
    input  logic [31:0] ptbr,
    input  logic        abort,
    output logic [31:0] ptw_adr_o,
    output logic        ptw_cyc_o,
    output logic        ptw_stb_o,
    input  logic [31:0] ptw_dat_i,
    input  logic        ptw_ack_i,
    input  logic        ptw_err_i,
    output logic [4:0]  csr_o,
    output logic [31:0] csr_write_data_o,
    output logic        csr_write_enable_o,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam int PAGE_BITS = $clog2(page_size);

    walk_state_t r_state;
    walk_state_t w_next;
    logic        r_req;
    logic [31:PAGE_BITS] r_vaddr;
    logic [31:PAGE_BITS] r_ptbase;
    logic [31:PAGE_BITS] r_l2base;
    logic [31:PAGE_BITS] r_pte;

    logic w_walking;
    logic w_bus;
    logic w_unused;

    assign w_unused  = ^{ptbr[PAGE_BITS-1:0], ptw_dat_i[PAGE_BITS-1:1]};
    assign w_walking = (r_state == S_L1) || (r_state == S_L2);
    // r_req low marks the address-setup cycle on entry to each level, forcing a bus gap.
    assign w_bus     = w_walking && r_req;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_vaddr  <= '0;
            r_ptbase <= '0;
            r_l2base <= '0;
            r_pte    <= '0;
        end else begin
            r_state <= w_next;
            r_req   <= w_walking && (w_next == r_state);
            if (r_state == S_IDLE && w_next == S_L1) begin
                r_vaddr  <= miss_addr[31:PAGE_BITS];
                r_ptbase <= ptbr[31:PAGE_BITS];
            end
            if (r_state == S_L1 && w_next == S_L2) begin
                r_l2base <= ptw_dat_i[31:PAGE_BITS];
            end
            if (r_state == S_L2 && w_next == S_WR_V) begin
                r_pte <= ptw_dat_i[31:PAGE_BITS];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && enable) begin
                    w_next = S_L1;
                end
            end
            S_L1, S_L2: begin
                // Priority: abort, then error, then ack.
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_bus && ptw_err_i) begin
                    w_next = S_FAULT;
                end else if (w_bus && ptw_ack_i) begin
                    if (!pte_valid(ptw_dat_i)) begin
                        w_next = S_FAULT;
                    end else if (r_state == S_L1) begin
                        w_next = S_L2;
                    end else begin
                        w_next = S_WR_V;
                    end
                end
            end
            S_WR_V:  w_next = S_WR_P;
            S_WR_P:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ptw_adr_o          = '0;
        csr_o              = '0;
        csr_write_data_o   = '0;
        csr_write_enable_o = 1'b0;
        ptw_cyc_o          = w_bus && !abort;
        ptw_stb_o          = w_bus && !abort;
        busy               = (r_state != S_IDLE);
        done               = (r_state == S_DONE);
        fault              = (r_state == S_FAULT);
        unique case (r_state)
            S_L1: ptw_adr_o = {r_ptbase, r_vaddr[L1_IDX_HI:L1_IDX_LO], 2'b00};
            S_L2: ptw_adr_o = {r_l2base, r_vaddr[L2_IDX_HI:L2_IDX_LO], 2'b00};
            S_WR_V: begin
                csr_write_enable_o = 1'b1;
                csr_o              = LM32_CSR_TLB_VADDRESS;
                csr_write_data_o   = {r_vaddr, 11'b0, 1'b1};
            end
            S_WR_P: begin
                csr_write_enable_o = 1'b1;
                csr_o              = LM32_CSR_TLB_PADDRESS;
                csr_write_data_o   = {r_pte, 11'b0, 1'b1};
            end
            default: ;
        endcase
    end

endmodule
